alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/seq_regfile.sv | 35 +++
 rtl/alu_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcode/state enums and command field positions for alu_sequencer
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_CAS = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESOLVE = 2'd2
    } state_e;

    localparam int CMD_OP_MSB = 11;
    localparam int CMD_OP_LSB = 9;
    localparam int CMD_A1_MSB = 8;
    localparam int CMD_A1_LSB = 6;
    localparam int CMD_A2_MSB = 5;
    localparam int CMD_A2_LSB = 3;
    localparam int CMD_A3_MSB = 2;
    localparam int CMD_A3_LSB = 0;

    localparam logic [2:0] STATUS_REG = 3'd7;

endpackage

// File: rtl/seq_regfile.sv
// rtl/seq_regfile.sv - register file: one write port, two read ports, one debug read port
module seq_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        raddr_a,
    input  logic [2:0]        raddr_b,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a  = regs[raddr_a];
    assign rdata_b  = regs[raddr_b];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - 3-cycle command sequencer around an external ALU; CAS enabled by ALU_SEQ_CAS_EN
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [11:0]       command,
    output logic [2:0]        alu_op_code,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    input  logic [DATA_W-1:0] y,
    input  logic              O,
    input  logic              C,
    input  logic              Z,
    input  logic              N,
    output logic              done,
    output logic [3:0]        flags,
    output logic              cas_ok,
    output logic              err,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_e            state, state_nxt;
    logic [11:0]       cmd_q;
    logic [2:0]        op, a1, a2, a3;
    logic              cas_cmd, illegal;
    logic              stat_pend, stat_val;
    logic              we;
    logic [2:0]        waddr, raddr_b;
    logic [DATA_W-1:0] wdata, rdata_a, rdata_b;

    assign op = cmd_q[CMD_OP_MSB:CMD_OP_LSB];
    assign a1 = cmd_q[CMD_A1_MSB:CMD_A1_LSB];
    assign a2 = cmd_q[CMD_A2_MSB:CMD_A2_LSB];
    assign a3 = cmd_q[CMD_A3_MSB:CMD_A3_LSB];

    assign cmd_ready = (state == IDLE);

    // CAS compares against R[addr3] in ISSUE, then fetches the swap value R[addr2] in RESOLVE
    assign raddr_b = (cas_cmd && state == ISSUE) ? a3 : a2;

    seq_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr_a  (a1),
        .raddr_b  (raddr_b),
        .dbg_addr (dbg_addr),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESOLVE;
            RESOLVE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The CAS status write lands in the IDLE cycle after RESOLVE, so it always follows the swap
    always_comb begin
        we    = 1'b0;
        waddr = a3;
        wdata = y;
        if (stat_pend) begin
            we    = 1'b1;
            waddr = STATUS_REG;
            wdata = {{(DATA_W-1){1'b0}}, stat_val};
        end else if (state == RESOLVE && !illegal) begin
            if (cas_cmd) begin
                we    = Z && (a3 != STATUS_REG);
                wdata = rdata_b;
            end else begin
                we    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q       <= '0;
            alu_op_code <= '0;
            data_a      <= '0;
            data_b      <= '0;
            flags       <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= (state == RESOLVE);
            err  <= (state == RESOLVE) && illegal;
            if (state == IDLE && cmd_valid) begin
                cmd_q <= command;
            end
            if (state == ISSUE && !illegal) begin
                alu_op_code <= cas_cmd ? OP_SUB : op;
                data_a      <= rdata_a;
                data_b      <= rdata_b;
            end
            if (state == RESOLVE) begin
                flags <= {O, C, Z, N};
            end
        end
    end

`ifdef ALU_SEQ_CAS_EN
    logic cas_ok_q;

    assign cas_cmd = (op == OP_CAS);
    assign illegal = 1'b0;
    assign cas_ok  = cas_ok_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cas_ok_q  <= 1'b0;
            stat_pend <= 1'b0;
            stat_val  <= 1'b0;
        end else begin
            stat_pend <= 1'b0;
            if (state == RESOLVE && cas_cmd) begin
                cas_ok_q  <= Z;
                stat_pend <= 1'b1;
                stat_val  <= Z;
            end
        end
    end
`else
    assign cas_cmd   = 1'b0;
    assign illegal   = (op == OP_CAS);
    assign cas_ok    = 1'b0;
    assign stat_pend = 1'b0;
    assign stat_val  = 1'b0;
`endif

endmodule
